// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT address sequencer and the address generator
// it drives.
//   - fft_state_e : sequencer state; each value equals the addr_mode encoding,
//                   so the mode output is the state register itself.
//   - MODE_*      : input_mode encodings understood by the address generator.
//   - DEF_*       : default transform geometry (256 points, 8 stages).
//   - *_W         : fixed widths of the externally visible counters.
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int DEF_N_STAGES = 8;
  localparam int DEF_N_ITER   = 32;
  localparam int DEF_GROUP    = 8;

  localparam int SAMPLE_W = 4;
  localparam int ITER_W   = 5;
  localparam int STAGE_W  = 4;

  localparam logic [1:0] MODE_IDLE    = 2'b00;
  localparam logic [1:0] MODE_LOAD    = 2'b01;
  localparam logic [1:0] MODE_COMPUTE = 2'b10;
  localparam logic [1:0] MODE_UNLOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = MODE_IDLE,
    ST_LOAD    = MODE_LOAD,
    ST_COMPUTE = MODE_COMPUTE,
    ST_UNLOAD  = MODE_UNLOAD
  } fft_state_e;

  // The state encoding doubles as the address generator mode.
  function automatic logic [1:0] state_to_mode(input fft_state_e s);
    return s;
  endfunction

endpackage

// File: rtl/fft_group_counter.sv
// -----------------------------------------------------------------------------
// fft_group_counter
// Two-level counter used for the load and unload passes: a sample index that
// runs 0..GROUP-1 and an iteration index that advances each time the sample
// index wraps, itself wrapping after N_ITER-1.
// Ports:
//   clk          in   system clock
//   nrst         in   asynchronous active-low reset
//   clr_i        in   synchronous clear (has priority over adv_i)
//   adv_i        in   advance by one sample
//   idx_o        out  registered sample index
//   iter_next_o  out  next-state value of the iteration index (lets the parent
//                     register a shared iteration output without extra delay)
//   last_o       out  current position is the final sample of the final group
// -----------------------------------------------------------------------------
module fft_group_counter
  import fft_pkg::*;
#(
  parameter int GROUP  = DEF_GROUP,
  parameter int N_ITER = DEF_N_ITER
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                clr_i,
  input  logic                adv_i,
  output logic [SAMPLE_W-1:0] idx_o,
  output logic [ITER_W-1:0]   iter_next_o,
  output logic                last_o
);

  localparam logic [SAMPLE_W-1:0] IDX_LAST  = SAMPLE_W'(GROUP - 1);
  localparam logic [ITER_W-1:0]   ITER_LAST = ITER_W'(N_ITER - 1);

  logic [SAMPLE_W-1:0] idx_q, idx_d;
  logic [ITER_W-1:0]   iter_q, iter_d;

  always_comb begin
    idx_d  = idx_q;
    iter_d = iter_q;
    if (clr_i) begin
      idx_d  = '0;
      iter_d = '0;
    end else if (adv_i) begin
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        iter_d = (iter_q == ITER_LAST) ? '0 : iter_q + ITER_W'(1);
      end else begin
        idx_d = idx_q + SAMPLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_q  <= '0;
      iter_q <= '0;
    end else begin
      idx_q  <= idx_d;
      iter_q <= iter_d;
    end
  end

  assign idx_o       = idx_q;
  assign iter_next_o = iter_d;
  assign last_o      = (idx_q == IDX_LAST) && (iter_q == ITER_LAST);

endmodule

// File: rtl/fft_addr_sequencer.sv
// -----------------------------------------------------------------------------
// fft_addr_sequencer
// Control FSM for an in-place FFT: IDLE -> LOAD -> COMPUTE -> UNLOAD -> IDLE.
// Tracks the sample/iteration/stage position the address generator needs and
// publishes it as registered outputs.
// Optional feature: define FFT_SEQ_ERR_EN to add the sticky seq_err output.
// Ports:
//   clk                in   system clock
//   nrst               in   asynchronous active-low reset
//   start              in   begin a transform (accepted only in IDLE)
//   abort              in   synchronous return to IDLE from any state
//   sample_valid       in   LOAD advance
//   bfly_done          in   COMPUTE advance
//   out_ready          in   UNLOAD advance
//   addr_mode          out  00 idle, 01 load, 10 compute, 11 unload
//   samples_in_count   out  sample index within current load group
//   samples_out_count  out  sample index within current unload group
//   iteration_count    out  current iteration
//   stage_count        out  current compute stage
//   busy               out  not IDLE
//   done               out  one-cycle pulse after the final unload handshake
//   seq_err            out  (FFT_SEQ_ERR_EN only) sticky protocol violation
// -----------------------------------------------------------------------------
module fft_addr_sequencer
  import fft_pkg::*;
#(
  parameter int N_STAGES = DEF_N_STAGES,
  parameter int N_ITER   = DEF_N_ITER,
  parameter int GROUP    = DEF_GROUP
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic                abort,
  input  logic                sample_valid,
  input  logic                bfly_done,
  input  logic                out_ready,
  output logic [1:0]          addr_mode,
  output logic [SAMPLE_W-1:0] samples_in_count,
  output logic [SAMPLE_W-1:0] samples_out_count,
  output logic [ITER_W-1:0]   iteration_count,
  output logic [STAGE_W-1:0]  stage_count,
  output logic                busy,
  output logic                done
`ifdef FFT_SEQ_ERR_EN
  ,
  output logic                seq_err
`endif
);

  // Counter widths are fixed by the interface; refuse geometries that overflow.
  if (N_ITER < 1 || N_ITER > 32) begin : g_chk_iter
    $error("fft_addr_sequencer: N_ITER must be in 1..32");
  end
  if (GROUP < 1 || GROUP > 16) begin : g_chk_group
    $error("fft_addr_sequencer: GROUP must be in 1..16");
  end
  if (N_STAGES < 1 || N_STAGES > 16) begin : g_chk_stages
    $error("fft_addr_sequencer: N_STAGES must be in 1..16");
  end

  localparam logic [ITER_W-1:0]  ITER_LAST  = ITER_W'(N_ITER - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_STAGES - 1);

  fft_state_e state_q, state_d;

  logic [ITER_W-1:0]  comp_iter_q, comp_iter_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [ITER_W-1:0]  iter_cnt_q, iter_cnt_d;
  logic               busy_q, done_q, done_d;

  logic               load_clr, load_adv, load_last;
  logic               unl_clr, unl_adv, unl_last;
  logic [ITER_W-1:0]  load_iter_next, unl_iter_next;

  // ---------------------------------------------------------------------------
  // Load and unload position counters
  // ---------------------------------------------------------------------------
  fft_group_counter #(
    .GROUP  (GROUP),
    .N_ITER (N_ITER)
  ) u_load_cnt (
    .clk         (clk),
    .nrst        (nrst),
    .clr_i       (load_clr),
    .adv_i       (load_adv),
    .idx_o       (samples_in_count),
    .iter_next_o (load_iter_next),
    .last_o      (load_last)
  );

  fft_group_counter #(
    .GROUP  (GROUP),
    .N_ITER (N_ITER)
  ) u_unload_cnt (
    .clk         (clk),
    .nrst        (nrst),
    .clr_i       (unl_clr),
    .adv_i       (unl_adv),
    .idx_o       (samples_out_count),
    .iter_next_o (unl_iter_next),
    .last_o      (unl_last)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    comp_iter_d = comp_iter_q;
    stage_d     = stage_q;
    load_adv    = 1'b0;
    unl_adv     = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (sample_valid) begin
            load_adv = 1'b1;
            if (load_last) begin
              state_d = ST_COMPUTE;
            end
          end
        end
        ST_COMPUTE: begin
          if (bfly_done) begin
            if (comp_iter_q == ITER_LAST) begin
              comp_iter_d = '0;
              if (stage_q == STAGE_LAST) begin
                state_d = ST_UNLOAD;
              end else begin
                stage_d = stage_q + STAGE_W'(1);
              end
            end else begin
              comp_iter_d = comp_iter_q + ITER_W'(1);
            end
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            unl_adv = 1'b1;
            if (unl_last) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Each counter group only holds a value while its own state is active;
    // leaving the state (normally or by abort) returns it to zero.
    if (state_d != ST_COMPUTE) begin
      comp_iter_d = '0;
      stage_d     = '0;
    end
  end

  assign load_clr = (state_d != ST_LOAD);
  assign unl_clr  = (state_d != ST_UNLOAD);

  // Inactive counters are forced to zero, so OR-ing the next values selects
  // the one belonging to the upcoming state.
  assign iter_cnt_d = load_iter_next | comp_iter_d | unl_iter_next;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      comp_iter_q <= '0;
      stage_q     <= '0;
      iter_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      comp_iter_q <= comp_iter_d;
      stage_q     <= stage_d;
      iter_cnt_q  <= iter_cnt_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
    end
  end

  assign addr_mode       = state_to_mode(state_q);
  assign iteration_count = iter_cnt_q;
  assign stage_count     = stage_q;
  assign busy            = busy_q;
  assign done            = done_q;

`ifdef FFT_SEQ_ERR_EN
  // ---------------------------------------------------------------------------
  // Sticky protocol-violation flag. An accepted start clears history, but a
  // violation seen in that same cycle still registers.
  // ---------------------------------------------------------------------------
  logic seq_err_q, seq_err_d;
  logic seq_viol, start_accept;

  always_comb begin
    seq_viol     = (sample_valid && (state_q != ST_LOAD))   ||
                   (out_ready    && (state_q != ST_UNLOAD)) ||
                   (start        && (state_q != ST_IDLE));
    start_accept = start && !abort && (state_q == ST_IDLE);
    seq_err_d    = (start_accept ? 1'b0 : seq_err_q) | seq_viol;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`endif

endmodule
